dsky_relay_decoder: RTL and testbench

- DSKY-side receiver for the AGC relay-word outputs RLYB01..RLYB11 and RYWD12/13/14/16.
- Synchronises the asynchronous relay lines, filters relay chatter with a stability window, and commits each settled word into a 12-row register file.
- Flags changed rows and serves a read port that returns the raw 11-bit row word plus both digits decoded from relay code to BCD.
- Runs in the prop_clk domain beside the fpga_agc instance; feeds display/monitor logic.

---
 rtl/dsky_pkg.sv | 38 +++
 rtl/relay_digit_decode.sv | 28 ++
 rtl/dsky_relay_decoder.sv | 176 +++++++++++++++++
 tb/tb_dsky_relay_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsky_pkg.sv
// rtl/dsky_pkg.sv - shared constants, relay codes and FSM state type for the DSKY relay decoder
package dsky_pkg;

    // Row addresses carried on RYWD12..16
    localparam logic [3:0] ROW_NONE  = 4'd0;
    localparam logic [3:0] ROW_NOUN  = 4'd9;
    localparam logic [3:0] ROW_VERB  = 4'd10;
    localparam logic [3:0] ROW_PROG  = 4'd11;
    localparam logic [3:0] ROW_LAMPS = 4'd12;

    // 5-bit relay codes for decimal digits
    localparam logic [4:0] RC_BLANK = 5'd0;
    localparam logic [4:0] RC_0     = 5'd21;
    localparam logic [4:0] RC_1     = 5'd3;
    localparam logic [4:0] RC_2     = 5'd25;
    localparam logic [4:0] RC_3     = 5'd27;
    localparam logic [4:0] RC_4     = 5'd15;
    localparam logic [4:0] RC_5     = 5'd30;
    localparam logic [4:0] RC_6     = 5'd28;
    localparam logic [4:0] RC_7     = 5'd19;
    localparam logic [4:0] RC_8     = 5'd29;
    localparam logic [4:0] RC_9     = 5'd31;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    // Rows 1..12 exist; row 0 means all relays released, 13..15 are unused.
    function automatic logic row_valid(input logic [3:0] row);
        return (row != ROW_NONE) && (row <= ROW_LAMPS);
    endfunction

endpackage

// File: rtl/relay_digit_decode.sv
// rtl/relay_digit_decode.sv - combinational 5-bit relay code to BCD digit
// Ports: code (in, 5) relay code; bcd (out, 4) digit 0..9, 4'hF blank, 4'hE invalid.
module relay_digit_decode
    import dsky_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] bcd
);

    always_comb begin
        bcd = BCD_INVALID;
        case (code)
            RC_BLANK: bcd = BCD_BLANK;
            RC_0:     bcd = 4'd0;
            RC_1:     bcd = 4'd1;
            RC_2:     bcd = 4'd2;
            RC_3:     bcd = 4'd3;
            RC_4:     bcd = 4'd4;
            RC_5:     bcd = 4'd5;
            RC_6:     bcd = 4'd6;
            RC_7:     bcd = 4'd7;
            RC_8:     bcd = 4'd8;
            RC_9:     bcd = 4'd9;
            default:  bcd = BCD_INVALID;
        endcase
    end

endmodule

// File: rtl/dsky_relay_decoder.sv
// rtl/dsky_relay_decoder.sv - DSKY relay-word receiver: sync, settle filter, 12-row store, BCD read port
// Ports: clk, rst (sync active-high); rlyb_in[10:0], rywd_in[3:0] async relay lines;
//        rd_row in, rd_word/rd_flag/rd_dig_a/rd_dig_b registered read data;
//        upd_stb/upd_row commit strobe; row_dirty/dirty_clr per-row change flags.
// Option: DSKY_VNFLSH_EN adds vnflsh_in, blanking noun/verb digits while it is high.
module dsky_relay_decoder
    import dsky_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2048,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] rlyb_in,
    input  logic [3:0]  rywd_in,
    input  logic [3:0]  rd_row,
    output logic [10:0] rd_word,
    output logic        rd_flag,
    output logic [3:0]  rd_dig_a,
    output logic [3:0]  rd_dig_b,
    output logic        upd_stb,
    output logic [3:0]  upd_row,
    output logic [11:0] row_dirty,
    input  logic [11:0] dirty_clr
`ifdef DSKY_VNFLSH_EN
    ,
    input  logic        vnflsh_in
`endif
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(SETTLE_CYCLES - 1);

    logic [14:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [10:0] pend_word_q, pend_word_d;
    logic [3:0]  upd_row_q, upd_row_d;
    logic [10:0] rows_q [12:1];
    logic [10:0] rows_d [12:1];
    logic [11:0] dirty_q, dirty_d;
    logic [11:0] set_mask;
    logic [10:0] rd_word_q, rd_word_d;
    logic [3:0]  rd_dig_a_q, rd_dig_a_d, rd_dig_b_q, rd_dig_b_d;

    logic [3:0]  w_row;
    logic [10:0] w_word;
    logic        diff;

    assign w_row  = sync2_q[14:11];
    assign w_word = sync2_q[10:0];
    // The newer sample (sync1) differing from w means w is about to change;
    // counting from here makes the window exactly SETTLE_CYCLES samples of w.
    assign diff   = (sync1_q != sync2_q);

    assign sync1_d = {rywd_in, rlyb_in};
    assign sync2_d = sync1_q;

    always_comb begin
        state_d     = state_q;
        pend_word_d = pend_word_q;
        upd_row_d   = upd_row_q;
        rows_d      = rows_q;
        set_mask    = '0;

        if (diff)
            cnt_d = '0;
        else if (cnt_q != CNT_LIMIT)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // Word is captured here so a change arriving during COMMIT
                // cannot corrupt what gets written.
                if (!diff && (cnt_q == CNT_LIMIT) && row_valid(w_row)) begin
                    state_d     = ST_COMMIT;
                    pend_word_d = w_word;
                    upd_row_d   = w_row;
                end
            end
            ST_COMMIT: begin
                for (int r = 1; r <= 12; r++) begin
                    if (upd_row_q == 4'(r)) begin
                        rows_d[r]     = pend_word_q;
                        set_mask[r-1] = 1'b1;
                    end
                end
                state_d = diff ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (diff)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        dirty_d = (dirty_q & ~dirty_clr) | set_mask;

        // Reading from rows_d forwards a same-cycle commit to the read port.
        rd_word_d = '0;
        for (int r = 1; r <= 12; r++) begin
            if (rd_row == 4'(r))
                rd_word_d = rows_d[r];
        end
    end

    // Unaddressed rows leave rd_word_d at 0, which decodes to blank digits.
    relay_digit_decode u_dec_a (.code(rd_word_d[9:5]), .bcd(rd_dig_a_d));
    relay_digit_decode u_dec_b (.code(rd_word_d[4:0]), .bcd(rd_dig_b_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            pend_word_q <= '0;
            upd_row_q   <= '0;
            for (int r = 1; r <= 12; r++)
                rows_q[r] <= '0;
            dirty_q     <= '0;
            rd_word_q   <= '0;
            rd_dig_a_q  <= BCD_BLANK;
            rd_dig_b_q  <= BCD_BLANK;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            pend_word_q <= pend_word_d;
            upd_row_q   <= upd_row_d;
            rows_q      <= rows_d;
            dirty_q     <= dirty_d;
            rd_word_q   <= rd_word_d;
            rd_dig_a_q  <= rd_dig_a_d;
            rd_dig_b_q  <= rd_dig_b_d;
        end
    end

    assign upd_stb   = (state_q == ST_COMMIT);
    assign upd_row   = upd_row_q;
    assign row_dirty = dirty_q;
    assign rd_word   = rd_word_q;
    assign rd_flag   = rd_word_q[10];

`ifdef DSKY_VNFLSH_EN
    logic vn_s1_q, vn_s1_d, vn_s2_q, vn_s2_d;
    logic [3:0] rd_row_q, rd_row_d;
    logic blank_nv;

    assign vn_s1_d  = vnflsh_in;
    assign vn_s2_d  = vn_s1_q;
    assign rd_row_d = rd_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            vn_s1_q  <= 1'b0;
            vn_s2_q  <= 1'b0;
            rd_row_q <= '0;
        end else begin
            vn_s1_q  <= vn_s1_d;
            vn_s2_q  <= vn_s2_d;
            rd_row_q <= rd_row_d;
        end
    end

    assign blank_nv = vn_s2_q && ((rd_row_q == ROW_NOUN) || (rd_row_q == ROW_VERB));
    assign rd_dig_a = blank_nv ? BCD_BLANK : rd_dig_a_q;
    assign rd_dig_b = blank_nv ? BCD_BLANK : rd_dig_b_q;
`else
    assign rd_dig_a = rd_dig_a_q;
    assign rd_dig_b = rd_dig_b_q;
`endif

endmodule

// File: tb/tb_dsky_relay_decoder.sv
// tb/tb_dsky_relay_decoder.sv - directed self-checking bench for dsky_relay_decoder
module tb_dsky_relay_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rlyb_in;
    logic [3:0]  rywd_in;
    logic [3:0]  rd_row;
    logic [10:0] rd_word;
    logic        rd_flag;
    logic [3:0]  rd_dig_a;
    logic [3:0]  rd_dig_b;
    logic        upd_stb;
    logic [3:0]  upd_row;
    logic [11:0] row_dirty;
    logic [11:0] dirty_clr;
`ifdef DSKY_VNFLSH_EN
    logic        vnflsh_in;
`endif

    int checks = 0;
    int errors = 0;
    int w_cnt;
    int w_first;
    logic [3:0] w_row;

    localparam logic [10:0] W10 = 11'b0_11001_00011;
    localparam logic [10:0] W5  = 11'b1_00011_10101;
    localparam logic [10:0] W3  = 11'b0_11011_01111;
    localparam logic [10:0] W4  = 11'b0_11110_11100;
    localparam logic [10:0] W6  = 11'b0_10011_11111;

    always #5 clk = ~clk;

    dsky_relay_decoder #(.SETTLE_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .rlyb_in(rlyb_in), .rywd_in(rywd_in),
        .rd_row(rd_row), .rd_word(rd_word), .rd_flag(rd_flag),
        .rd_dig_a(rd_dig_a), .rd_dig_b(rd_dig_b),
        .upd_stb(upd_stb), .upd_row(upd_row),
        .row_dirty(row_dirty), .dirty_clr(dirty_clr)
`ifdef DSKY_VNFLSH_EN
        , .vnflsh_in(vnflsh_in)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n cycles, sampling at each falling edge; records strobe count,
    // index of first strobe (cycles since inputs were applied) and its row.
    task automatic watch(input int n);
        w_cnt   = 0;
        w_first = -1;
        w_row   = 4'd0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (upd_stb) begin
                w_cnt++;
                if (w_first < 0) w_first = k;
                w_row = upd_row;
            end
        end
    endtask

    task automatic read_row(input logic [3:0] r);
        rd_row = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int total;
        rst = 1'b1; rlyb_in = '0; rywd_in = '0; rd_row = '0; dirty_clr = '0;
`ifdef DSKY_VNFLSH_EN
        vnflsh_in = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_upd_stb", 32'(upd_stb), 32'd0);
        chk("rst_upd_row", 32'(upd_row), 32'd0);
        chk("rst_dirty", 32'(row_dirty), 32'd0);
        chk("rst_rd_word", 32'(rd_word), 32'd0);
        chk("rst_rd_flag", 32'(rd_flag), 32'd0);
        chk("rst_dig_a", 32'(rd_dig_a), 32'hF);
        chk("rst_dig_b", 32'(rd_dig_b), 32'hF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Settle: row 10
        rywd_in = 4'd10; rlyb_in = W10;
        watch(40);
        chk("settle_first", 32'(w_first), 32'd18);
        chk("settle_count", 32'(w_cnt), 32'd1);
        chk("settle_row", 32'(w_row), 32'd10);
        chk("settle_dirty", 32'(row_dirty), 32'h200);
        read_row(4'd10);
        chk("settle_word", 32'(rd_word), 32'(W10));
        chk("settle_flag", 32'(rd_flag), 32'd0);
        chk("settle_dig_a", 32'(rd_dig_a), 32'd2);
        chk("settle_dig_b", 32'(rd_dig_b), 32'd1);

        // Chatter on row 5: ten changes 10 cycles apart, then final toggle
        rywd_in = 4'd5; rlyb_in = W5;
        watch(10);
        total = w_cnt;
        for (int i = 1; i <= 9; i++) begin
            rlyb_in[3] = ~rlyb_in[3];
            watch(10);
            total += w_cnt;
        end
        chk("chatter_none", 32'(total), 32'd0);
        rlyb_in[3] = ~rlyb_in[3];
        watch(40);
        chk("chatter_first", 32'(w_first), 32'd18);
        chk("chatter_count", 32'(w_cnt), 32'd1);
        chk("chatter_row", 32'(w_row), 32'd5);
        read_row(4'd5);
        chk("chatter_word", 32'(rd_word), 32'(W5));
        chk("chatter_flag", 32'(rd_flag), 32'd1);
        chk("chatter_dig_a", 32'(rd_dig_a), 32'd1);
        chk("chatter_dig_b", 32'(rd_dig_b), 32'd0);
        chk("chatter_dirty", 32'(row_dirty), 32'h210);

        // Row 0 and row 13 never commit
        rywd_in = 4'd0;
        watch(100);
        chk("row0_none", 32'(w_cnt), 32'd0);
        rywd_in = 4'd13;
        watch(100);
        chk("row13_none", 32'(w_cnt), 32'd0);
        chk("row13_dirty", 32'(row_dirty), 32'h210);
        read_row(4'd13);
        chk("rd13_word", 32'(rd_word), 32'd0);
        chk("rd13_dig_a", 32'(rd_dig_a), 32'hF);
        chk("rd13_dig_b", 32'(rd_dig_b), 32'hF);
        read_row(4'd1);
        chk("rd1_word", 32'(rd_word), 32'd0);

        // Re-send the same word via an intervening row 0
        rywd_in = 4'd3; rlyb_in = W3;
        watch(60);
        chk("resend1_count", 32'(w_cnt), 32'd1);
        chk("resend1_first", 32'(w_first), 32'd18);
        rywd_in = 4'd0;
        watch(20);
        chk("resend_gap", 32'(w_cnt), 32'd0);
        rywd_in = 4'd3;
        watch(40);
        chk("resend2_count", 32'(w_cnt), 32'd1);
        chk("resend2_first", 32'(w_first), 32'd18);
        read_row(4'd3);
        chk("resend_dig_a", 32'(rd_dig_a), 32'd3);
        chk("resend_dig_b", 32'(rd_dig_b), 32'd4);

        // Dirty set/clear collision on row 4
        dirty_clr = 12'hFFF;
        @(posedge clk); @(negedge clk);
        dirty_clr = '0;
        chk("clr_all", 32'(row_dirty), 32'd0);
        rywd_in = 4'd4; rlyb_in = W4;
        repeat (17) begin @(posedge clk); @(negedge clk); end
        @(posedge clk); @(negedge clk);
        chk("coll_stb", 32'(upd_stb), 32'd1);
        dirty_clr = 12'h008;
        @(posedge clk); @(negedge clk);
        dirty_clr = '0;
        chk("coll_set_wins", 32'(row_dirty), 32'h008);
        dirty_clr = 12'h008;
        @(posedge clk); @(negedge clk);
        dirty_clr = '0;
        chk("clr_alone", 32'(row_dirty), 32'd0);
        read_row(4'd4);
        chk("r4_dig_a", 32'(rd_dig_a), 32'd5);
        chk("r4_dig_b", 32'(rd_dig_b), 32'd6);

`ifdef DSKY_VNFLSH_EN
        vnflsh_in = 1'b1;
        repeat (3) @(negedge clk);
        read_row(4'd10);
        chk("vn_word", 32'(rd_word), 32'(W10));
        chk("vn_dig_a", 32'(rd_dig_a), 32'hF);
        chk("vn_dig_b", 32'(rd_dig_b), 32'hF);
        read_row(4'd4);
        chk("vn_r4_dig_a", 32'(rd_dig_a), 32'd5);
        vnflsh_in = 1'b0;
        repeat (3) @(negedge clk);
`endif

        // Reset when the settle counter reaches 8
        rywd_in = 4'd6; rlyb_in = W6;
        rd_row = 4'd3;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("mid_rst_stb", 32'(upd_stb), 32'd0);
        chk("mid_rst_row", 32'(upd_row), 32'd0);
        chk("mid_rst_dirty", 32'(row_dirty), 32'd0);
        chk("mid_rst_word", 32'(rd_word), 32'd0);
        chk("mid_rst_dig_a", 32'(rd_dig_a), 32'hF);
        chk("mid_rst_dig_b", 32'(rd_dig_b), 32'hF);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        watch(40);
        chk("post_rst_first", 32'(w_first), 32'd18);
        chk("post_rst_count", 32'(w_cnt), 32'd1);
        chk("post_rst_row", 32'(w_row), 32'd6);
        read_row(4'd6);
        chk("post_rst_dig_a", 32'(rd_dig_a), 32'd7);
        chk("post_rst_dig_b", 32'(rd_dig_b), 32'd9);
        read_row(4'd3);
        chk("post_rst_r3", 32'(rd_word), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
